// File: rtl/processor_run_ctrl.sv
// Run controller: debounces the board reset/run buttons, sequences the processor
// reset and enable (halted, free-running or single-step), and counts enabled cycles.
module processor_run_ctrl #(
   parameter int DEB_CYCLES = 1000000,
   parameter int RST_CYCLES = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk0,
   input  logic             rst0,
   input  logic             btn_rst,
   input  logic             btn_run,
   input  logic             step_mode,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic             running,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [1:0]       o_dbg_state
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_HALT  = 2'd1,
      S_RUN   = 2'd2,
      S_STEP  = 2'd3
   } state_t;

   // Button lanes: index 0 is run, index 1 is reset.
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_stable;
   logic [1:0]       r_press;
   logic [DEB_W-1:0] r_deb_cnt [2];

   state_t           r_state;
   state_t           w_next;
   logic [RST_W-1:0] r_rst_cnt;
   logic [RST_W-1:0] w_rst_cnt_next;
   logic             r_cpu_rst;
   logic             r_cpu_en;
   logic             r_running;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic             w_press_run;
   logic             w_press_rst;

   always_ff @(posedge clk0 or negedge rst0) begin
      if (!rst0) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_press  <= '0;
         for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
      end else begin
         r_sync1 <= {btn_rst, btn_run};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            r_press[i] <= 1'b0;
            if (r_sync2[i] == r_stable[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_LAST) begin
               // Accept the new level; only a rising acceptance is a press.
               r_stable[i]  <= r_sync2[i];
               r_deb_cnt[i] <= '0;
               r_press[i]   <= r_sync2[i];
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   assign w_press_run = r_press[0];
   assign w_press_rst = r_press[1];

   always_comb begin
      w_next         = r_state;
      w_rst_cnt_next = r_rst_cnt;
      if (w_press_rst) begin
         // Reset outranks a run press landing in the same cycle.
         w_next         = S_RESET;
         w_rst_cnt_next = RST_LAST;
      end else begin
         case (r_state)
            S_RESET: begin
               if (r_rst_cnt == '0) w_next = S_HALT;
               else                 w_rst_cnt_next = r_rst_cnt - RST_W'(1);
            end
            S_HALT:  if (w_press_run) w_next = step_mode ? S_STEP : S_RUN;
            S_RUN:   if (w_press_run) w_next = S_HALT;
            S_STEP:  w_next = S_HALT;
            default: w_next = S_RESET;
         endcase
      end
   end

   // Outputs are registered from the next state so they change with the state.
   always_ff @(posedge clk0 or negedge rst0) begin
      if (!rst0) begin
         r_state     <= S_RESET;
         r_rst_cnt   <= RST_LAST;
         r_cpu_rst   <= 1'b1;
         r_cpu_en    <= 1'b0;
         r_running   <= 1'b0;
         r_cycle_cnt <= '0;
      end else begin
         r_state   <= w_next;
         r_rst_cnt <= w_rst_cnt_next;
         r_cpu_rst <= (w_next == S_RESET);
         r_cpu_en  <= (w_next == S_RUN) || (w_next == S_STEP);
         r_running <= (w_next == S_RUN);
         if (w_next == S_RESET) r_cycle_cnt <= '0;
         else if (r_cpu_en)     r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
   end

   assign cpu_rst     = r_cpu_rst;
   assign cpu_en      = r_cpu_en;
   assign running     = r_running;
   assign cycle_cnt   = r_cycle_cnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_processor_run_ctrl.sv
// Bench for processor_run_ctrl: table of button actions with expected end states,
// plus hand-written sequences for power-up, bounce, stepping, wrap and async reset.
module tb_processor_run_ctrl;

   localparam int CW = 8;
   localparam int ST_RESET = 0;
   localparam int ST_HALT  = 1;
   localparam int ST_RUN   = 2;

   logic          clk0 = 1'b0;
   logic          rst0 = 1'b1;
   logic          btn_rst = 1'b0;
   logic          btn_run = 1'b0;
   logic          step_mode = 1'b0;
   logic          cpu_rst;
   logic          cpu_en;
   logic          running;
   logic [CW-1:0] cycle_cnt;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   processor_run_ctrl #(
      .DEB_CYCLES (4),
      .RST_CYCLES (3),
      .CNT_W      (CW)
   ) dut (
      .clk0        (clk0),
      .rst0        (rst0),
      .btn_rst     (btn_rst),
      .btn_run     (btn_run),
      .step_mode   (step_mode),
      .cpu_rst     (cpu_rst),
      .cpu_en      (cpu_en),
      .running     (running),
      .cycle_cnt   (cycle_cnt),
      .o_dbg_state (dbg_state)
   );

   always #5 clk0 = ~clk0;

   // Observer sampling on the falling edge: enabled-cycle model and pulse shapes.
   int unsigned mdl_cnt = 0;
   int unsigned exp_cnt = 0;
   int en_edges = 0, en_len = 0, en_last_len = 0;
   int rst_len = 0, rst_last_len = 0, rst_seqs = 0;
   int run_samples = 0, bad = 0;
   logic prev_en = 1'b0, prev_rst = 1'b0;

   always @(negedge clk0) begin
      if (cpu_rst) begin
         exp_cnt = 0;
         mdl_cnt = 0;
      end else begin
         exp_cnt = mdl_cnt;
         if (cpu_en) mdl_cnt = mdl_cnt + 1;
      end
      if (cpu_en && !prev_en) begin
         en_edges = en_edges + 1;
         en_len   = 1;
      end else if (cpu_en) begin
         en_len = en_len + 1;
      end else if (prev_en) begin
         en_last_len = en_len;
      end
      if (cpu_rst && !prev_rst)  rst_len = 1;
      else if (cpu_rst)          rst_len = rst_len + 1;
      else if (prev_rst) begin
         rst_last_len = rst_len;
         rst_seqs     = rst_seqs + 1;
      end
      if (running) run_samples = run_samples + 1;
      if ((cpu_en && cpu_rst) || (running && !cpu_en) || (cpu_rst && cycle_cnt != 0)) bad = bad + 1;
      prev_en  = cpu_en;
      prev_rst = cpu_rst;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk0);
      #1;
   endtask

   task automatic press(input logic run, input logic rst);
      @(posedge clk0);
      #1;
      btn_run = run;
      btn_rst = rst;
      repeat (10) @(posedge clk0);
      #1;
      btn_run = 1'b0;
      btn_rst = 1'b0;
      repeat (12) @(posedge clk0);
      sample();
   endtask

   // Called at negedge+1 with rst0 low: release, then cpu_rst drops on the third edge.
   task automatic release_and_check(input string tag);
      rst0 = 1'b1;
      sample();
      chk({tag, "_rst_e1"}, 32'(cpu_rst), 1);
      sample();
      chk({tag, "_rst_e2"}, 32'(cpu_rst), 1);
      sample();
      chk({tag, "_rst_e3"}, 32'(cpu_rst), 0);
      chk({tag, "_state"}, 32'(dbg_state), ST_HALT);
      chk({tag, "_en"}, 32'(cpu_en), 0);
      chk({tag, "_cnt"}, 32'(cycle_cnt), 0);
   endtask

   typedef struct {
      logic       run;
      logic       rst;
      logic       step;
      int         exp_state;
      logic       exp_running;
      logic       exp_en;
      int         exp_en_edges;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base_en, base_rst, base_run;

      // Each vector starts from HALT or the end state of the previous one.
      vecs[0]  = '{1'b1, 1'b0, 1'b1, ST_HALT, 1'b0, 1'b0, 1};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, ST_RUN,  1'b1, 1'b1, 1};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, ST_HALT, 1'b0, 1'b0, 0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, ST_RUN,  1'b1, 1'b1, 1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, ST_HALT, 1'b0, 1'b0, 0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, ST_HALT, 1'b0, 1'b0, 1};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, ST_HALT, 1'b0, 1'b0, 0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, ST_HALT, 1'b0, 1'b0, 0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, ST_RUN,  1'b1, 1'b1, 1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, ST_HALT, 1'b0, 1'b0, 0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, ST_HALT, 1'b0, 1'b0, 1};

      // Power-up
      #1 rst0 = 1'b0;
      repeat (5) @(posedge clk0);
      sample();
      chk("por_cpu_rst", 32'(cpu_rst), 1);
      chk("por_cpu_en", 32'(cpu_en), 0);
      chk("por_running", 32'(running), 0);
      chk("por_cnt", 32'(cycle_cnt), 0);
      chk("por_state", 32'(dbg_state), ST_RESET);
      release_and_check("por");

      // Bounce rejection: 1,1,0,0 pattern for 20 cycles, then hold high
      step_mode = 1'b0;
      base_en = en_edges;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk0);
         #1;
         btn_run = ((i / 2) % 2 == 0);
      end
      @(posedge clk0);
      #1;
      btn_run = 1'b1;
      repeat (6) @(posedge clk0);
      sample();
      chk("bounce_before_7", 32'(running), 0);
      sample();
      chk("bounce_running_at_7", 32'(running), 1);
      chk("bounce_en_at_7", 32'(cpu_en), 1);
      repeat (10) @(posedge clk0);
      #1;
      btn_run = 1'b0;
      repeat (15) @(posedge clk0);
      sample();
      chk("bounce_still_running", 32'(running), 1);
      chk("bounce_one_press", en_edges - base_en, 1);

      // Run/halt: second press halts and freezes the count
      press(1'b1, 1'b0);
      chk("halt_running", 32'(running), 0);
      chk("halt_en", 32'(cpu_en), 0);
      chk("halt_state", 32'(dbg_state), ST_HALT);
      chk("halt_cnt", 32'(cycle_cnt), int'(exp_cnt % 256));
      repeat (5) sample();
      chk("halt_cnt_frozen", 32'(cycle_cnt), int'(exp_cnt % 256));

      // Table-driven button actions
      for (int v = 0; v < 11; v++) begin
         step_mode = vecs[v].step;
         base_en  = en_edges;
         base_rst = rst_seqs;
         press(vecs[v].run, vecs[v].rst);
         chk($sformatf("vec%0d_state", v), 32'(dbg_state), vecs[v].exp_state);
         chk($sformatf("vec%0d_running", v), 32'(running), 32'(vecs[v].exp_running));
         chk($sformatf("vec%0d_en", v), 32'(cpu_en), 32'(vecs[v].exp_en));
         chk($sformatf("vec%0d_cpu_rst", v), 32'(cpu_rst), 0);
         chk($sformatf("vec%0d_cnt", v), 32'(cycle_cnt), int'(exp_cnt % 256));
         chk($sformatf("vec%0d_en_edges", v), en_edges - base_en, vecs[v].exp_en_edges);
         chk($sformatf("vec%0d_rst_seqs", v), rst_seqs - base_rst, 32'(vecs[v].rst));
         if (vecs[v].rst) chk($sformatf("vec%0d_rst_len", v), rst_last_len, 3);
      end

      // Single step: three isolated one-cycle enables after a reset
      step_mode = 1'b1;
      press(1'b0, 1'b1);
      chk("step_cnt_after_rst", 32'(cycle_cnt), 0);
      base_en  = en_edges;
      base_run = run_samples;
      for (int s = 0; s < 3; s++) begin
         press(1'b1, 1'b0);
         chk($sformatf("step%0d_width", s), en_last_len, 1);
      end
      chk("step_pulses", en_edges - base_en, 3);
      chk("step_never_running", run_samples - base_run, 0);
      chk("step_cnt", 32'(cycle_cnt), 3);

      // Wrap: 260 enabled cycles on an 8-bit counter
      step_mode = 1'b0;
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      for (int i = 0; i < 400 && exp_cnt < 260; i++) sample();
      chk("wrap_reached_260", int'(exp_cnt), 260);
      chk("wrap_cnt", 32'(cycle_cnt), 4);
      chk("wrap_running", 32'(running), 1);

      // Async reset mid-run, away from any clock edge
      #2;
      rst0 = 1'b0;
      #1;
      chk("async_cpu_rst", 32'(cpu_rst), 1);
      chk("async_en", 32'(cpu_en), 0);
      chk("async_running", 32'(running), 0);
      chk("async_cnt", 32'(cycle_cnt), 0);
      chk("async_state", 32'(dbg_state), ST_RESET);
      sample();
      release_and_check("async");

      chk("invariants", bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
